// File: rtl/wb_port_arbiter_if.sv
// Bundle of the two requester ports, the write-back output port and the
// conflict counter for wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_src;
  logic              wb_ready;
  logic [15:0]       conflict_cnt;

  modport slave (
    input  req0_valid, req0_data, req0_addr,
    input  req1_valid, req1_data, req1_addr,
    input  wb_ready,
    output req0_ready, req1_ready,
    output wb_valid, wb_data, wb_addr, wb_src,
    output conflict_cnt
  );

  modport master (
    output req0_valid, req0_data, req0_addr,
    output req1_valid, req1_data, req1_addr,
    output wb_ready,
    input  req0_ready, req1_ready,
    input  wb_valid, wb_data, wb_addr, wb_src,
    input  conflict_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered write-back
// slot; the slot can be refilled in the same cycle it is drained.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  wb_port_arbiter_if.slave    bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              wb_src_q, wb_src_d;
  logic              last_grant_q, last_grant_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  logic can_accept;
  logic gnt_any;
  logic gnt_idx;
  logic both_valid;

  // Grant selection; a tie goes to the requester that did not win last.
  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    can_accept = (state_q == ST_EMPTY) | bus.wb_ready;
    gnt_any    = 1'b0;
    gnt_idx    = 1'b0;
    if (reset || !can_accept) begin
      gnt_any = 1'b0;
      gnt_idx = 1'b0;
    end else if (both_valid) begin
      gnt_any = 1'b1;
      gnt_idx = ~last_grant_q;
    end else if (bus.req0_valid) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b0;
    end else if (bus.req1_valid) begin
      gnt_any = 1'b1;
      gnt_idx = 1'b1;
    end else begin
      gnt_any = 1'b0;
      gnt_idx = 1'b0;
    end
  end

  assign bus.req0_ready = gnt_any & ~gnt_idx;
  assign bus.req1_ready = gnt_any &  gnt_idx;

  // Next-state for the output slot, round-robin pointer and conflict counter.
  always_comb begin
    state_d        = state_q;
    wb_data_d      = wb_data_q;
    wb_addr_d      = wb_addr_q;
    wb_src_d       = wb_src_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (gnt_any) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (gnt_any) begin
          state_d = ST_FULL;
        end else if (bus.wb_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (gnt_any) begin
      wb_data_d    = gnt_idx ? bus.req1_data : bus.req0_data;
      wb_addr_d    = gnt_idx ? bus.req1_addr : bus.req0_addr;
      wb_src_d     = gnt_idx;
      last_grant_d = gnt_idx;
    end else begin
      wb_data_d    = wb_data_q;
      wb_addr_d    = wb_addr_q;
      wb_src_d     = wb_src_q;
      last_grant_d = last_grant_q;
    end

    // Saturates rather than wraps so a long-running count stays meaningful.
    if (both_valid && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // State registers; reset drops any held write regardless of wb_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_EMPTY;
      wb_data_q      <= {DATA_W{1'b0}};
      wb_addr_q      <= {ADDR_W{1'b0}};
      wb_src_q       <= 1'b0;
      last_grant_q   <= 1'b1;
      conflict_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wb_data_q      <= wb_data_d;
      wb_addr_q      <= wb_addr_d;
      wb_src_q       <= wb_src_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.wb_valid     = (state_q == ST_FULL);
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_src       = wb_src_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] a0,
                       input logic v1, input logic [31:0] d1, input logic [4:0] a1,
                       input logic rdy);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_addr  = a0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_addr  = a1;
    bus.wb_ready   = rdy;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic s);
    chk({tag, "_valid"}, {31'd0, bus.wb_valid}, {31'd0, v});
    chk({tag, "_data"},  bus.wb_data, d);
    chk({tag, "_addr"},  {27'd0, bus.wb_addr}, {27'd0, a});
    chk({tag, "_src"},   {31'd0, bus.wb_src}, {31'd0, s});
  endtask

  logic [1:0]  exp_rdy [4];
  logic [31:0] d0_tab  [4];
  logic [31:0] d1_tab  [4];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    d0_tab  = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
    d1_tab  = '{32'hB1B1_0000, 32'hB1B1_0001, 32'hB1B1_0002, 32'hB1B1_0003};

    // Reset: readies forced low even with a valid request.
    drive(1'b1, 32'h1111_1111, 5'd1, 1'b0, 32'd0, 5'd0, 1'b1);
    chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
    step();
    step();
    chk_out("rst", 1'b0, 32'd0, 5'd0, 1'b0);
    chk("rst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);

    // Single write from req0, one-cycle latency.
    reset = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0, 32'd0, 5'd0, 1'b1);
    chk("s1_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("s1_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1);
    chk_out("s1", 1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0);
    step();
    chk("s1_drain", {31'd0, bus.wb_valid}, 32'd0);

    // req1 alone, then a tie: req0 must win.
    drive(1'b0, 32'd0, 5'd0, 1'b1, 32'h0000_0011, 5'd7, 1'b1);
    chk("s6_rdy1", {31'd0, bus.req1_ready}, 32'd1);
    step();
    chk_out("s6a", 1'b1, 32'h0000_0011, 5'd7, 1'b1);
    drive(1'b1, 32'h0000_00A0, 5'd1, 1'b1, 32'h0000_00B1, 5'd2, 1'b1);
    chk("s6_tie", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    step();
    chk_out("s6b", 1'b1, 32'h0000_00A0, 5'd1, 1'b0);
    chk("s6_cnt", {16'd0, bus.conflict_cnt}, 32'd1);

    // Continuous tie after reset: grants alternate 0,1,0,1.
    reset = 1'b1;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d0_tab[i], 5'd10, 1'b1, d1_tab[i], 5'd20, 1'b1);
      chk("s2_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, exp_rdy[i]});
      step();
      if (exp_rdy[i] == 2'b01) begin
        chk_out("s2", 1'b1, d0_tab[i], 5'd10, 1'b0);
      end else begin
        chk_out("s2", 1'b1, d1_tab[i], 5'd20, 1'b1);
      end
      chk("s2_cnt", {16'd0, bus.conflict_cnt}, i + 1);
    end

    // Stall: FULL holding 0x12345678 with wb_ready low, req1 waiting.
    drive(1'b1, 32'h1234_5678, 5'd9, 1'b0, 32'd0, 5'd0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 5'd12, 1'b0);
      chk("s3_rdy1", {31'd0, bus.req1_ready}, 32'd0);
      chk_out("s3_hold", 1'b1, 32'h1234_5678, 5'd9, 1'b0);
      step();
    end
    chk_out("s3_hold_end", 1'b1, 32'h1234_5678, 5'd9, 1'b0);
    drive(1'b0, 32'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 5'd12, 1'b1);
    chk("s3_rel", {31'd0, bus.req1_ready}, 32'd1);
    step();
    chk_out("s3_new", 1'b1, 32'hCAFE_F00D, 5'd12, 1'b1);

    // Reset while FULL (last grant = req0) with wb_ready high.
    drive(1'b1, 32'h0000_0055, 5'd4, 1'b0, 32'd0, 5'd0, 1'b1);
    step();
    chk_out("s5_pre", 1'b1, 32'h0000_0055, 5'd4, 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h0000_0066, 5'd5, 1'b1, 32'h0000_0077, 5'd6, 1'b1);
    chk("s5_rst_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    step();
    chk_out("s5_rst", 1'b0, 32'd0, 5'd0, 1'b0);
    chk("s5_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    reset = 1'b0;
    #1;
    chk("s5_tie", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);

    // Saturation: tie held with the consumer stalled; counts regardless.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 32'h0000_0001, 5'd1, 1'b1, 32'h0000_0002, 5'd2, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    chk("s4_cnt_65534", {16'd0, bus.conflict_cnt}, 32'd65534);
    chk_out("s4_stall", 1'b1, 32'h0000_0001, 5'd1, 1'b0);
    step();
    chk("s4_cnt_65535", {16'd0, bus.conflict_cnt}, 32'd65535);
    step();
    step();
    chk("s4_cnt_sat", {16'd0, bus.conflict_cnt}, 32'd65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5, the register-file address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1, requester k offers a write.
REQ-006 SHALL have ports req0_data / req1_data, input, DATA_W, requester k write data.
REQ-007 SHALL have ports req0_addr / req1_addr, input, ADDR_W, requester k destination register.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1, requester k's offer is accepted this cycle.
REQ-009 SHALL have port wb_valid, output, 1, the output register holds a pending write.
REQ-010 SHALL have port wb_data, output, DATA_W, registered write data.
REQ-011 SHALL have port wb_addr, output, ADDR_W, registered destination.
REQ-012 SHALL have port wb_src, output, 1, the requester index that produced the held write.
REQ-013 SHALL have port wb_ready, input, 1, the consumer takes the write when wb_valid and wb_ready are both high.
REQ-014 SHALL have port conflict_cnt, output, 16, saturating count of cycles with both requests valid.

Function
REQ-015 SHALL define transfer_k = reqk_valid & reqk_ready, and wb_fire = wb_valid & wb_ready.
REQ-016 SHALL use two states: EMPTY (wb_valid=0) and FULL (wb_valid=1).
REQ-017 SHALL define can_accept = EMPTY | (FULL & wb_ready); this is purely combinational.
REQ-018 SHALL assert at most one reqk_ready in any cycle.
REQ-019 SHALL never assert reqk_ready when can_accept=0.
REQ-020 SHALL grant the only valid requester when exactly one is valid and can_accept=1.
REQ-021 SHALL, when both are valid and can_accept=1, grant the requester not equal to last_grant (round-robin).
REQ-022 SHALL update last_grant to the granted index only on a transfer.
REQ-023 SHALL drive reqk_ready independent of reqk_data and reqk_addr.
REQ-024 SHALL, on transfer_k, load wb_data/wb_addr from reqk, set wb_src=k and enter FULL on the next edge (latency 1 cycle).
REQ-025 SHALL, on wb_fire with no transfer, enter EMPTY.
REQ-026 SHALL, on wb_fire with a simultaneous transfer, stay FULL with the new contents (back-to-back, 1 write/cycle).
REQ-027 SHALL, in FULL with wb_ready=0, hold wb_data/wb_addr/wb_src stable and keep both readies low.
REQ-028 SHALL increment conflict_cnt whenever req0_valid & req1_valid, regardless of readiness.
REQ-029 SHALL hold conflict_cnt at 16'hFFFF once reached (no wrap).
REQ-030 SHALL treat a requester that drops valid without a transfer as a legal withdrawal; this does not change last_grant.

Reset
REQ-031 SHALL, with reset high at an edge, set state=EMPTY, wb_valid=0, wb_data=0, wb_addr=0, wb_src=0, last_grant=1 (so req0 wins the first tie) and conflict_cnt=0.
REQ-032 SHALL force req0_ready=req1_ready=0 while reset is high.
REQ-033 SHALL discard any held write when reset is asserted mid-operation, even when wb_ready is high in that cycle.

Verification
REQ-034 SHALL pass this scenario: after reset, req0_valid=1 with data 0xDEADBEEF and addr 3, wb_ready=1 -> req0_ready=1 in that cycle; next cycle wb_valid=1, wb_data=0xDEADBEEF, wb_addr=3, wb_src=0.
REQ-035 SHALL pass this scenario: both valid continuously, wb_ready=1 -> grants alternate 0,1,0,1 starting with 0; one write per cycle; conflict_cnt increments by 1 each cycle.
REQ-036 SHALL pass this scenario: FULL holding 0x12345678, wb_ready=0 for 3 cycles, req1 valid -> outputs stable and req1_ready=0 for those cycles; wb_ready=1 -> req1_ready=1 that cycle and its data is presented next cycle.
REQ-037 SHALL pass this scenario: both valid with conflict_cnt preloaded near saturation (65534) -> the count reaches 65535 and stays there.
REQ-038 SHALL pass this scenario: reset asserted while FULL with wb_ready=1 -> next cycle wb_valid=0, all outputs 0, and the next tie is granted to req0.
REQ-039 SHALL pass this scenario: req1 alone, then both valid -> req0 wins the tie, because last_grant=1 after the req1 transfer.
